// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM controller among NREQ requesters; all outputs registered.
// Define DRAM_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead of round-robin.
module dram_arbiter #(
    parameter int NREQ = 4,
    parameter int AIN  = 8,
    parameter int PW   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AIN-1:0] req_addr,
    input  logic [NREQ-1:0]     req_rw,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     req_ack,
    output logic                mem_as_n,
    output logic [AIN-1:0]      mem_addr,
    output logic                mem_rw,
    input  logic                mem_ack,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   req_ack_q;
    logic              as_n_q;
    logic [AIN-1:0]    addr_q;
    logic              rw_q;
    logic              busy_q;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    int                idx;
`endif

    logic [PW-1:0]       win_d;
    logic                any_d;
    logic [NREQ-1:0]     req_sh;
    logic [NREQ-1:0]     onehot_d;
    logic [NREQ*AIN-1:0] addr_sh;
    logic [AIN-1:0]      addr_d;
    logic [NREQ-1:0]     rw_sh;
    logic                rw_d;

    // Winner search: loop runs from lowest to highest priority so the last hit is the winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        win_d  = '0;
        any_d  = 1'b0;
        req_sh = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            req_sh = req >> i;
            if (req_sh[0]) begin
                win_d = PW'(i);
                any_d = 1'b1;
            end
        end
`else
        idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx    = (int'(ptr_q) + k) % NREQ;
            req_sh = req >> idx;
            if (req_sh[0]) begin
                win_d = PW'(idx);
                any_d = 1'b1;
            end
        end
`endif
        onehot_d = NREQ'(1) << win_d;
        addr_sh  = req_addr >> (int'(win_d) * AIN);
        addr_d   = addr_sh[AIN-1:0];
        rw_sh    = req_rw >> win_d;
        rw_d     = rw_sh[0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            req_ack_q <= '0;
            as_n_q    <= 1'b1;
            addr_q    <= '0;
            rw_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            ptr_q     <= PW'(NREQ - 1);
            win_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        gnt_q   <= onehot_d;
                        addr_q  <= addr_d;
                        rw_q    <= rw_d;
                        as_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifndef DRAM_ARB_FIXED_PRIO_EN
                        win_q   <= win_d;
`endif
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Strobe drops on the ack edge so the controller never sees a second request.
                    if (mem_ack) begin
                        as_n_q    <= 1'b1;
                        req_ack_q <= gnt_q;
`ifndef DRAM_ARB_FIXED_PRIO_EN
                        ptr_q     <= win_q;
`endif
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    req_ack_q <= '0;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign req_ack  = req_ack_q;
    assign mem_as_n = as_n_q;
    assign mem_addr = addr_q;
    assign mem_rw   = rw_q;
    assign busy     = busy_q;

endmodule
